// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard controller for a 5-stage in-order pipeline. Detects
//             load-use hazards, squashes wrong-path instructions on EX
//             redirects, freezes the pipe while data memory is busy, halts on
//             a memory timeout and keeps saturating stall/flush counters.
//  Ports    : clk, reset (async, active-low)
//             id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 : ID operand usage
//             ex_rd/ex_mem_read/ex_redirect         : EX instruction info
//             mem_busy                              : data memory not ready
//             clr_counters                          : sync counter clear
//             pc_en..mem_wb_en                      : stage enables (comb)
//             if_id_flush/id_ex_flush               : bubble insertion (comb)
//             state, mem_timeout, stall_count, flush_count : status
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             clr_counters,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_HALT       = 2'd3
    } state_e;

    // wait_cnt counts busy edges already spent in MEM_WAIT (entry edge = 1)
    localparam logic [7:0]       C_WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic             w_load_use;
    logic [4:0]       w_en;          // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic             w_if_id_flush;
    logic             w_id_ex_flush;

    // A load to x0 never produces a value, so it can never cause a hazard.
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        w_en          = 5'b11111;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            ST_RUN, ST_LOAD_STALL, ST_MEM_WAIT: begin
                if (mem_busy) begin
                    w_en = 5'b00000;
                    if (state_q == ST_MEM_WAIT) begin
                        if (wait_cnt_q >= C_WAIT_LIMIT) begin
                            state_d       = ST_HALT;
                            mem_timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else begin
                        state_d    = ST_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end else if (state_q == ST_LOAD_STALL) begin
                    // Bubble already inserted: release without re-evaluating.
                    state_d = ST_RUN;
                end else if (ex_redirect) begin
                    // Redirect outranks load-use: the stalled ID instr is wrong-path.
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                    state_d       = ST_RUN;
                end else if (w_load_use) begin
                    w_en[4]       = 1'b0;
                    w_en[3]       = 1'b0;
                    w_id_ex_flush = 1'b1;
                    state_d       = ST_LOAD_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                w_en = 5'b00000;
            end
        endcase

        // Outputs must be quiet while reset is held, independent of clk.
        if (!reset) begin
            w_en          = 5'b00000;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (clr_counters) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (!w_en[4] && (state_q != ST_HALT) && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + C_CNT_ONE;
            end
            if (w_if_id_flush && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + C_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign pc_en       = w_en[4];
    assign if_id_en    = w_en[3];
    assign id_ex_en    = w_en[2];
    assign ex_mem_en   = w_en[1];
    assign mem_wb_en   = w_en[0];
    assign if_id_flush = w_if_id_flush;
    assign id_ex_flush = w_id_ex_flush;
    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl. The driver applies
//             one input vector per cycle and queues the hand-computed
//             response; an independent monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W       = 3;
    localparam int MEM_TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_uses_rs1, id_uses_rs2;
    logic             ex_mem_read, ex_redirect, mem_busy, clr_counters;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush;
    logic [1:0]       state;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .mem_busy(mem_busy), .clr_counters(clr_counters),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .state(state), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]       st;
        logic [4:0]       en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic [1:0]       fl;   // {if_id_flush, id_ex_flush}
        logic             mt;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  chk_pulse = 1'b0;

    localparam logic [4:0] E_ALL  = 5'b11111;
    localparam logic [4:0] E_NONE = 5'b00000;
    localparam logic [4:0] E_LU   = 5'b00111;

    // ---------------- monitor ----------------
    always begin
        @(negedge clk or posedge chk_pulse);
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = '{st: state,
                   en: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
                   fl: {if_id_flush, id_ex_flush},
                   mt: mem_timeout, sc: stall_count, fc: flush_count};
            n_checks++;
            if (a === e) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%0d en=%b fl=%b mt=%b sc=%0d fc=%0d, expected st=%0d en=%b fl=%b mt=%b sc=%0d fc=%0d",
                         nm, a.st, a.en, a.fl, a.mt, a.sc, a.fc,
                         e.st, e.en, e.fl, e.mt, e.sc, e.fc);
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic push_exp(input string nm, input int st, input logic [4:0] en,
                            input logic [1:0] fl, input logic mt, input int sc, input int fc);
        exp_t e;
        e.st = 2'(st); e.en = en; e.fl = fl; e.mt = mt;
        e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Queue the response for the inputs now applied, then advance one cycle.
    task automatic step(input string nm, input int st, input logic [4:0] en,
                        input logic [1:0] fl, input logic mt, input int sc, input int fc);
        push_exp(nm, st, en, fl, mt, sc, fc);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0; mem_busy = 1'b0; clr_counters = 1'b0;
    endtask

    task automatic load_use_rs1();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step("reset_state", 0, E_NONE, 2'b00, 0, 0, 0);
        reset = 1'b1;
        step("run_idle", 0, E_ALL, 2'b00, 0, 0, 0);

        // load-use on rs1, then the stall cycle ignores the still-present hazard
        load_use_rs1();
        step("load_use_rs1", 0, E_LU, 2'b01, 0, 0, 0);
        step("load_stall", 1, E_ALL, 2'b00, 0, 1, 0);
        ex_rd = 5'd0; id_rs1 = 5'd0;
        step("load_x0", 0, E_ALL, 2'b00, 0, 1, 0);
        load_use_rs1(); id_uses_rs1 = 1'b0;
        step("unused_rs1", 0, E_ALL, 2'b00, 0, 1, 0);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        step("load_use_rs2", 0, E_LU, 2'b01, 0, 1, 0);
        idle();
        step("after_rs2", 1, E_ALL, 2'b00, 0, 2, 0);

        // redirect outranks load-use
        load_use_rs1(); ex_redirect = 1'b1;
        step("redirect_prio", 0, E_ALL, 2'b11, 0, 2, 0);
        idle();
        step("after_redirect", 0, E_ALL, 2'b00, 0, 2, 1);

        // memory wait (mem_busy outranks redirect), exit straight into a load-use
        idle(); mem_busy = 1'b1; ex_redirect = 1'b1;
        step("busy1", 0, E_NONE, 2'b00, 0, 2, 1);
        step("busy2", 2, E_NONE, 2'b00, 0, 3, 1);
        step("busy3", 2, E_NONE, 2'b00, 0, 4, 1);
        load_use_rs1();
        step("memwait_load_use", 2, E_LU, 2'b01, 0, 5, 1);
        idle();
        step("ls_after_mw", 1, E_ALL, 2'b00, 0, 6, 1);
        mem_busy = 1'b1;
        step("busy_short", 0, E_NONE, 2'b00, 0, 6, 1);
        mem_busy = 1'b0;
        step("busy_release", 2, E_ALL, 2'b00, 0, 7, 1);
        step("run_after_mw", 0, E_ALL, 2'b00, 0, 7, 1);

        // clear coincident with a stall
        load_use_rs1(); clr_counters = 1'b1;
        step("clr_with_stall", 0, E_LU, 2'b01, 0, 7, 1);
        idle();
        step("after_clr", 1, E_ALL, 2'b00, 0, 0, 0);

        // timeout: fourth busy edge lands in HALT
        mem_busy = 1'b1;
        step("to_busy1", 0, E_NONE, 2'b00, 0, 0, 0);
        step("to_busy2", 2, E_NONE, 2'b00, 0, 1, 0);
        step("to_busy3", 2, E_NONE, 2'b00, 0, 2, 0);
        step("to_busy4", 2, E_NONE, 2'b00, 0, 3, 0);
        step("halt", 3, E_NONE, 2'b00, 1, 4, 0);
        mem_busy = 1'b0; ex_redirect = 1'b1;
        step("halt_persist", 3, E_NONE, 2'b00, 1, 4, 0);
        idle(); reset = 1'b0;
        step("reset_from_halt", 0, E_NONE, 2'b00, 0, 0, 0);
        reset = 1'b1;
        step("post_reset_halt", 0, E_ALL, 2'b00, 0, 0, 0);

        // stall counter saturation, then async reset in MEM_WAIT
        for (int i = 0; i < 5; i++) begin
            load_use_rs1();
            step("sat_load_use", 0, E_LU, 2'b01, 0, i, 0);
            idle();
            step("sat_stall", 1, E_ALL, 2'b00, 0, i + 1, 0);
        end
        mem_busy = 1'b1;
        step("sat_busy1", 0, E_NONE, 2'b00, 0, 5, 0);
        step("sat_busy2", 2, E_NONE, 2'b00, 0, 6, 0);
        step("sat_busy3", 2, E_NONE, 2'b00, 0, 7, 0);
        push_exp("stall_saturated", 2, E_NONE, 2'b00, 0, 7, 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        push_exp("async_reset_mw", 0, E_NONE, 2'b00, 0, 0, 0);
        chk_pulse = 1'b1;
        #1;
        chk_pulse = 1'b0;
        @(posedge clk);
        #1;
        idle(); reset = 1'b1;
        step("post_reset_mw", 0, E_ALL, 2'b00, 0, 0, 0);

        // flush counter saturation
        ex_redirect = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step("redirect_run", 0, E_ALL, 2'b11, 0, 0, (i > 7) ? 7 : i);
        end
        idle();
        step("flush_saturated", 0, E_ALL, 2'b00, 0, 0, 7);

        repeat (3) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
